bcd_updown_counter: RTL and testbench

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit.sv | 53 +++++
 rtl/bcd_updown_counter.sv | 94 +++++++++
 tb/tb_bcd_updown_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and types for the up/down decade counter.
// Provides the digit width, the legal digit range and a digit-legality helper.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    // True when a nibble is a legal decimal digit.
    function automatic logic bcd_is_legal(input bcd_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade with its own registered digit.
// Ports:
//   clk, reset     - clock, synchronous active-high reset (digit -> 0)
//   load           - replace the digit with load_digit (already validated)
//   load_digit     - digit value to load
//   step_in        - step this decade once in the up_dn direction
//   up_dn          - 1 = up, 0 = down
//   digit          - registered digit value
//   carry_out      - combinational: at 9 going up, or at 0 going down
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  bcd_t load_digit,
    input  logic step_in,
    input  logic up_dn,
    output bcd_t digit,
    output logic carry_out
);

    bcd_t digit_q;
    bcd_t digit_d;

    always_comb begin
        carry_out = up_dn ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
    end

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_digit;
        end else if (step_in) begin
            if (up_dn) begin
                digit_d = carry_out ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = carry_out ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-decade BCD up/down counter with wrap or saturate at the terminal value,
// synchronous parallel load with digit validation, and pulse outputs.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   enable       - count-step qualifier
//   up_dn        - 1 = count up, 0 = count down
//   load         - parallel-load strobe (wins over enable)
//   load_value   - BCD value to load, digit 0 in [3:0]
//   count        - registered BCD count, digit 0 in [3:0]
//   tc           - combinational: enable and count at the terminal value
//   done         - one-cycle pulse after an enabled step taken at terminal
//   load_err     - one-cycle pulse after a load with an illegal digit
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned SATURATE   = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        up_dn,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
    output logic [BCD_W*NUM_DIGITS-1:0] count,
    output logic                        tc,
    output logic                        done,
    output logic                        load_err
);

    logic [NUM_DIGITS-1:0] carry;
    logic [NUM_DIGITS-1:0] step_in;
    logic                  load_ok;
    logic                  at_term;
    logic                  step_en;
    logic                  done_q;
    logic                  done_d;
    logic                  load_err_q;
    logic                  load_err_d;

    always_comb begin
        load_ok = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!bcd_is_legal(load_value[i*BCD_W +: BCD_W])) begin
                load_ok = 1'b0;
            end
        end
    end

    // Every decade signalling carry means the whole count sits at the
    // terminal value for the current direction.
    always_comb begin
        at_term    = &carry;
        // In saturate mode the step is suppressed at terminal; in wrap mode
        // the ripple through all decades performs the wrap naturally.
        step_en    = enable && !load && !((SATURATE != 0) && at_term);
        done_d     = enable && !load && at_term;
        load_err_d = load && !load_ok;
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_first
            assign step_in[i] = step_en;
        end else begin : g_rest
            assign step_in[i] = step_in[i-1] & carry[i-1];
        end

        bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (load && load_ok),
            .load_digit (load_value[i*BCD_W +: BCD_W]),
            .step_in    (step_in[i]),
            .up_dn      (up_dn),
            .digit      (count[i*BCD_W +: BCD_W]),
            .carry_out  (carry[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign tc       = enable && at_term;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: three counters (3-digit wrap, 3-digit saturate,
// 1-digit wrap) share stimulus; an integer reference model predicts outputs.
module tb_bcd_updown_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        up_dn = 1'b1;
    logic        load = 1'b0;
    logic [11:0] load_value = '0;

    logic [11:0] c0, c1;
    logic [3:0]  c2;
    logic        tc0, tc1, tc2;
    logic        dn0, dn1, dn2;
    logic        er0, er1, er2;

    always #5 clk = ~clk;

    bcd_updown_counter #(.NUM_DIGITS(3), .SATURATE(0)) u_w3 (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_value(load_value), .count(c0), .tc(tc0), .done(dn0), .load_err(er0));

    bcd_updown_counter #(.NUM_DIGITS(3), .SATURATE(1)) u_s3 (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_value(load_value), .count(c1), .tc(tc1), .done(dn1), .load_err(er1));

    bcd_updown_counter #(.NUM_DIGITS(1), .SATURATE(0)) u_w1 (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_value(load_value[3:0]), .count(c2), .tc(tc2), .done(dn2), .load_err(er2));

    typedef struct packed {
        logic [11:0] c0;
        logic [11:0] c1;
        logic [3:0]  c2;
        logic [2:0]  tc;
        logic [2:0]  done;
        logic [2:0]  err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    int   checks = 0;
    int   errors = 0;
    int   mv[3] = '{0, 0, 0};
    int   nd[3] = '{3, 3, 1};
    int   sat[3] = '{0, 1, 0};

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r = '0;
        int t = v;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs and push the model's prediction of the
    // outputs as seen just after the following rising edge.
    task automatic drive(input logic r, input logic e, input logic u,
                         input logic l, input logic [11:0] lv);
        exp_t x;
        int maxv, lval, nib;
        logic valid, term, dn, er;
        logic [11:0] b;
        @(negedge clk);
        reset = r; enable = e; up_dn = u; load = l; load_value = lv;
        x = '0;
        for (int k = 0; k < 3; k++) begin
            maxv = pow10(nd[k]) - 1;
            dn = 1'b0;
            er = 1'b0;
            if (r) begin
                mv[k] = 0;
            end else if (l) begin
                valid = 1'b1;
                lval = 0;
                for (int i = 0; i < nd[k]; i++) begin
                    nib = int'(lv[i*4 +: 4]);
                    if (nib > 9) valid = 1'b0;
                    lval += nib * pow10(i);
                end
                if (valid) mv[k] = lval;
                else er = 1'b1;
            end else if (e) begin
                term = u ? (mv[k] == maxv) : (mv[k] == 0);
                dn = term;
                if (term) begin
                    if (sat[k] == 0) mv[k] = u ? 0 : maxv;
                end else begin
                    mv[k] = u ? mv[k] + 1 : mv[k] - 1;
                end
            end
            x.tc[k]   = e && (u ? (mv[k] == maxv) : (mv[k] == 0));
            x.done[k] = dn;
            x.err[k]  = er;
            b = to_bcd(mv[k]);
            if (k == 0) x.c0 = b;
            else if (k == 1) x.c1 = b;
            else x.c2 = b[3:0];
        end
        sb.push_back(x);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_x = sb.pop_front();
                chk("count_w3", c0, mon_x.c0);
                chk("count_s3", c1, mon_x.c1);
                chk("count_w1", {8'h0, c2}, {8'h0, mon_x.c2});
                chk("tc", {9'h0, tc2, tc1, tc0}, {9'h0, mon_x.tc});
                chk("done", {9'h0, dn2, dn1, dn0}, {9'h0, mon_x.done});
                chk("load_err", {9'h0, er2, er1, er0}, {9'h0, mon_x.err});
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sel;
        logic [11:0] lv;
        // Reset then count up through the full range and one wrap.
        drive(1, 0, 1, 0, 12'h000);
        drive(1, 0, 1, 0, 12'h000);
        for (int i = 0; i < 1000; i++) drive(0, 1, 1, 0, 12'h000);
        drive(0, 0, 1, 0, 12'h000);
        // Load 100, count down twice.
        drive(0, 0, 0, 1, 12'h100);
        drive(0, 1, 0, 0, 12'h000);
        drive(0, 1, 0, 0, 12'h000);
        // Load 998, count up four times.
        drive(0, 0, 1, 1, 12'h998);
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, 12'h000);
        drive(0, 0, 1, 0, 12'h000);
        // Illegal load digit, then idle to see the pulse drop.
        drive(0, 0, 1, 1, 12'h1A3);
        drive(0, 0, 1, 0, 12'h000);
        // Load against enable.
        drive(0, 0, 1, 1, 12'h555);
        drive(0, 1, 1, 1, 12'h123);
        drive(0, 0, 1, 0, 12'h000);
        // Reset against enable at terminal.
        drive(0, 0, 1, 1, 12'h999);
        drive(1, 1, 1, 0, 12'h000);
        drive(0, 0, 1, 0, 12'h000);
        // Count down from zero to exercise the down wrap.
        drive(0, 1, 0, 0, 12'h000);
        drive(0, 1, 0, 0, 12'h000);
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: lv = 12'($urandom);
                1: lv = 12'h999;
                2: lv = 12'h000;
                3: lv = 12'h998;
                4: lv = 12'h001;
                default: begin
                    lv = '0;
                    for (int d = 0; d < 3; d++) lv[d*4 +: 4] = 4'($urandom_range(0, 9));
                end
            endcase
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75,
                  1'($urandom_range(0, 1)), $urandom_range(0, 99) < 10, lv);
        end
        drive(0, 0, 1, 0, 12'h000);
        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
